fc_layer_seq: RTL

//  Parametrised fully connected CNN layer; one signed MAC time-shared over all inputs.

---
 rtl/cnn_fc_pkg.sv | 33 +++
 rtl/fc_layer_seq_if.sv | 25 ++
 rtl/fc_mac.sv | 26 ++
 rtl/fc_layer_seq.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/cnn_fc_pkg.sv
// Shared state encoding and elaboration/arithmetic helpers for the fully connected layer.
package cnn_fc_pkg;

  typedef enum logic [1:0] {FILL, COMPUTE, OUT} fc_state_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Counter/index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (clog2(n) > 0) ? clog2(n) : 1;
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/fc_layer_seq_if.sv
// Frame input beat stream and per-neuron score stream of the fully connected layer.
interface fc_layer_seq_if #(
  parameter int IN_CH  = 3,
  parameter int DATA_W = 12,
  parameter int IDX_W  = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [IN_CH*DATA_W-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic [IDX_W-1:0]        out_idx;
  logic                    out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/fc_mac.sv
// Registered signed MAC: load seeds the accumulator with a bias, en adds the full a*b product.
// acc_nxt is the value an en cycle stores, so the caller can capture the final sum on the same edge.
module fc_mac #(
  parameter int A_W   = 12,
  parameter int B_W   = 8,
  parameter int ACC_W = 28
) (
  input  logic                    clk,
  input  logic                    load,
  input  logic                    en,
  input  logic signed [B_W-1:0]   bias,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc_nxt
);
  logic signed [A_W+B_W-1:0] prod;
  logic signed [ACC_W-1:0]   acc_q;

  assign prod    = a * b;
  assign acc_nxt = acc_q + ACC_W'(prod);

  always_ff @(posedge clk) begin
    if (load) acc_q <= ACC_W'(bias);
    else if (en) acc_q <= acc_nxt;
  end
endmodule

// File: rtl/fc_layer_seq.sv
// Fully connected layer: buffers one IN_CH x IN_LEN frame, then walks one MAC over it per neuron.
// Score valid N edges after the final beat; input stalls (in_ready=0) until the last score is taken.
module fc_layer_seq
  import cnn_fc_pkg::*;
#(
  parameter int IN_CH      = 3,
  parameter int IN_LEN     = 16,
  parameter int OUT_NUM    = 10,
  parameter int DATA_W     = 12,
  parameter int W_W        = 8,
  parameter int ACC_W      = 28,
  parameter int FRAC_SHIFT = 7,
  parameter int RELU       = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  fc_layer_seq_if.slave                      io,
  input  logic [OUT_NUM*IN_CH*IN_LEN*W_W-1:0] w_fc,
  input  logic [OUT_NUM*W_W-1:0]              b_fc
);
  localparam int N    = IN_CH * IN_LEN;
  localparam int T_W  = idx_w(IN_LEN);
  localparam int K_W  = idx_w(N);
  localparam int J_W  = idx_w(OUT_NUM);
  localparam int WS_W = idx_w(OUT_NUM * N * W_W);
  localparam int BS_W = idx_w(OUT_NUM * W_W);

  if (ACC_W < DATA_W + W_W + clog2(N) + 1) begin : g_acc_w_chk
    $error("fc_layer_seq: ACC_W too narrow for worst-case dot product");
  end

  fc_state_t state;
  logic [T_W-1:0] t;
  logic [K_W-1:0] k;
  logic [J_W-1:0] j;

  logic signed [DATA_W-1:0] buf_q [N];

  logic [WS_W-1:0]          w_base;
  logic [BS_W-1:0]          b_base;
  logic signed [W_W-1:0]    w_sel;
  logic signed [W_W-1:0]    b_sel;
  logic                     mac_load;
  logic                     mac_en;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [ACC_W-1:0]  r_shift;
  logic [DATA_W-1:0]        res;

  // Channel-major layout: buf[c*IN_LEN + t], matching the weight column index k.
  always_ff @(posedge clk) begin
    if (rst_n && state == FILL && io.in_valid && io.in_ready) begin
      for (int c = 0; c < IN_CH; c++) begin
        buf_q[K_W'(c * IN_LEN) + K_W'(t)] <= io.in_data[c*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_base   = WS_W'((int'(j) * N + int'(k)) * W_W);
    b_base   = BS_W'((((state == OUT) && (j != J_W'(OUT_NUM - 1))) ? int'(j) + 1 : 0) * W_W);
    mac_load = ((state == FILL) && io.in_valid && io.in_ready && (t == T_W'(IN_LEN - 1))) ||
               ((state == OUT) && io.out_ready && (j != J_W'(OUT_NUM - 1)));
    mac_en   = (state == COMPUTE);
    r_shift  = acc_nxt >>> FRAC_SHIFT;
    if (RELU != 0 && r_shift < 0) r_shift = '0;
    res      = DATA_W'(sat(64'(r_shift), DATA_W));
  end

  assign w_sel = w_fc[w_base +: W_W];
  assign b_sel = b_fc[b_base +: W_W];

  fc_mac #(
    .A_W   (DATA_W),
    .B_W   (W_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk     (clk),
    .load    (mac_load),
    .en      (mac_en),
    .bias    (b_sel),
    .a       (buf_q[k]),
    .b       (w_sel),
    .acc_nxt (acc_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= FILL;
      t            <= '0;
      k            <= '0;
      j            <= '0;
      io.in_ready  <= 1'b1;
      io.out_valid <= 1'b0;
      io.out_data  <= '0;
      io.out_idx   <= '0;
      io.out_last  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (io.in_valid && io.in_ready) begin
            if (t == T_W'(IN_LEN - 1)) begin
              t           <= '0;
              k           <= '0;
              j           <= '0;
              io.in_ready <= 1'b0;
              state       <= COMPUTE;
            end else begin
              t <= t + 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (k == K_W'(N - 1)) begin
            k            <= '0;
            io.out_valid <= 1'b1;
            io.out_data  <= res;
            io.out_idx   <= j;
            io.out_last  <= (j == J_W'(OUT_NUM - 1));
            state        <= OUT;
          end else begin
            k <= k + 1'b1;
          end
        end
        OUT: begin
          if (io.out_ready) begin
            io.out_valid <= 1'b0;
            if (j != J_W'(OUT_NUM - 1)) begin
              j     <= j + 1'b1;
              k     <= '0;
              state <= COMPUTE;
            end else begin
              j           <= '0;
              io.in_ready <= 1'b1;
              state       <= FILL;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule
